intt_sdf_stage: RTL and testbench
=================================

Name: intt_sdf_stage

Overview:
- One radix-2 Gentleman-Sande (decimation-in-frequency) single-path delay-feedback stage for the 64-point inverse NTT pipeline.
- It is the inverse-direction counterpart of the forward NTT SDF stage.
- Six instances, with index 0..5, chain to form the INTT datapath. An INTT control unit supplies the twiddle factors (inverse powers of psi).
- The stage tracks its own phase counter and stalls on in_valid gaps.

Parameters:
- data_width, 64, width of every coefficient word.
- modulo, 7681, NTT prime q; all arithmetic is mod q.
- index, 0, stage index; delay depth D = 2**index (1..32).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  stage_in carries a sample this cycle; the stage advances only when high
- stage_in  in  data_width  input coefficient, 0..q-1
- tw_factor  in  data_width  twiddle, 0..q-1; sampled on advancing phase-0 cycles
- tw_phase  out  1  current phase (cnt[index]); lets the controller align twiddles
- stage_out  out  data_width  registered result, 0..q-1
- out_valid  out  1  registered; stage_out is meaningful this cycle

Behaviour:
- State:
  - cnt, index+1 bits, wraps mod 2D.
  - primed flag.
  - Circular delay buffer, depth D, head pointer.
  - stage_out and out_valid registers.
- Reset (async, any time including mid-frame): cnt=0, primed=0, all buffer words=0, stage_out=0, out_valid=0. There is no partial-frame recovery.
- Non-advancing cycle (in_valid=0): no state changes; out_valid<=0; stage_out holds its value.
- Advancing cycle, phase 0 (cnt<D):
  - d = buf[head].
  - stage_out <= (d*tw_factor) mod q, full 2*data_width product.
  - buf[head] <= stage_in.
- Advancing cycle, phase 1 (cnt>=D):
  - a = buf[head], b = stage_in.
  - stage_out <= (a+b) mod q.
  - buf[head] <= (a-b) mod q.
- Every advancing cycle: head increments mod D and cnt increments mod 2D.
- primed sets at the first advancing phase-1 cycle and stays set until reset.
- out_valid <= in_valid && (primed || phase==1). The garbage products of the first phase-0 block are suppressed.
- Modular add: s=a+b; if s>=q then s-q.
- Modular subtract: if a>=b then a-b, else a-b+q.
- Inputs at or above q are illegal. The result is unspecified and no check is made.
- Latency:
  - The sum for pair (i, i+D) appears the cycle after input i+D is accepted.
  - The difference-times-twiddle for that pair appears the cycle after the i-th phase-0 input of the next block is accepted, i.e. D advancing cycles later.
- Drain: upstream supplies D extra in_valid cycles (any data) after the last frame to flush the buffered differences.
- Stalls: any in_valid gap pattern produces an identical output sequence, compressed to the valid cycles.
- index=0: D=1; the buffer is a single register and the phase toggles every advancing cycle.

Optional Feature:
- Macro INTT_STAGE_SCALE_EN.
- Defined: the phase-1 sum is halved mod q before registering: h = s even ? s/2 : (s+q)/2. Six stages then apply the distributed n^-1 = 2^-6 scaling. The difference path is unchanged, because halving is folded into the twiddle ROM values.
- Undefined: the sum is unscaled, and the top level applies n^-1 separately.

Decomposition:
- Package ntt_pkg holds:
  - DATA_WIDTH=64, MODULO=7681, N=64, ADDR_WIDTH=6, INV2=3841, N_INV=(64^-1 mod 7681)=7561.
  - Functions mod_add, mod_sub, mod_mul, mod_half, shared with the forward stage.
- Sub-module sdf_delay_buffer (parameters depth, data_width):
  - Circular register buffer with head pointer and async reset.
  - Read-before-write on the same push.

Test Plan:
- index=0, tw=2, inputs 5,3,0: out_valid on cycles 2,3; stage_out 8 (5+3), then 4 ((5-3)*2).
- index=0, inputs 3,5,x with tw=1: sum 8; difference wraps to 7679 (3-5+7681).
- index=0, inputs 7680,1: sum 0 (mod wrap). With INTT_STAGE_SCALE_EN, inputs 4,3 -> sum output 3844 ((7+7681)/2).
- index=5, ramp 0..63 then 32 drain samples, tw=1:
  - First out_valid follows input #32.
  - Sums are 32,34,..,94.
  - Then 32 outputs of 7649 (i-(i+32)+q).
- index=2, in_valid toggling 1010..: the output sequence equals the gap-free run; out_valid is never high on cycles after an in_valid=0 cycle.
- index=3, assert rst_n low mid-block: stage_out=0, out_valid=0 immediately. After release, a fresh frame matches the golden model with no stale buffer data.

Source files
------------

// File: rtl/ntt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ntt_pkg: shared constants and modular helpers for the NTT/INTT SDF |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package ntt_pkg;

  localparam int          DATA_WIDTH = 64;
  localparam int unsigned MODULO     = 7681;
  localparam int          N          = 64;
  localparam int          ADDR_WIDTH = 6;
  localparam int unsigned INV2       = 3841;
  localparam int unsigned N_INV      = 7561;

  typedef logic [DATA_WIDTH-1:0] word_t;

  function automatic int stage_depth(input int index);
    return 1 << index;
  endfunction

  function automatic word_t mod_add(input word_t a, input word_t b, input word_t q);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return word_t'(s);
  endfunction

  // Unsigned wrap of a-b is exact here, so adding q lands back in 0..q-1.
  function automatic word_t mod_sub(input word_t a, input word_t b, input word_t q);
    return (a >= b) ? (a - b) : (a - b + q);
  endfunction

  function automatic word_t mod_mul(input word_t a, input word_t b, input word_t q);
    logic [2*DATA_WIDTH-1:0] p;
    p = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    p = p % {{DATA_WIDTH{1'b0}}, q};
    return word_t'(p);
  endfunction

  // Odd values take the (s+q)/2 route; q is odd so the sum is even.
  function automatic word_t mod_half(input word_t s, input word_t q);
    logic [DATA_WIDTH:0] t;
    t = {1'b0, s};
    if (s[0]) t = t + {1'b0, q};
    return word_t'(t >> 1);
  endfunction

endpackage : ntt_pkg
`default_nettype wire

// File: rtl/sdf_delay_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdf_delay_buffer: circular feedback register buffer, read-before-  |
// | write on each push, head pointer advances per push.                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sdf_delay_buffer #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  generate
    if (DEPTH == 1) begin : g_single
      assign dout = r_mem[0];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[0] <= '0;
        end else if (push) begin
          r_mem[0] <= din;
        end
      end
    end else begin : g_ring
      localparam int PTR_W = $clog2(DEPTH);
      logic [PTR_W-1:0] r_head;

      assign dout = r_mem[r_head];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_head <= '0;
          for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (push) begin
          r_mem[r_head] <= din;
          r_head        <= (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + PTR_W'(1);
        end
      end
    end
  endgenerate

endmodule : sdf_delay_buffer
`default_nettype wire

// File: rtl/intt_sdf_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | intt_sdf_stage: radix-2 Gentleman-Sande SDF stage of the 64-pt INTT|
// | Option INTT_STAGE_SCALE_EN: halve the phase-1 sum (split n^-1).    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module intt_sdf_stage #(
  parameter int          DATA_WIDTH = 64,
  parameter int unsigned MODULO     = 7681,
  parameter int          INDEX      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] stage_in,
  input  logic [DATA_WIDTH-1:0] tw_factor,
  output logic                  tw_phase,
  output logic [DATA_WIDTH-1:0] stage_out,
  output logic                  out_valid
);

  import ntt_pkg::*;

  localparam int    DEPTH = stage_depth(INDEX);
  localparam word_t c_q   = word_t'(MODULO);

  logic [INDEX:0]        r_cnt;
  logic                  r_primed;
  logic                  w_phase;
  logic [DATA_WIDTH-1:0] w_buf_rd;
  logic [DATA_WIDTH-1:0] w_buf_wr;
  logic [DATA_WIDTH-1:0] w_result;
  word_t                 w_a;
  word_t                 w_b;
  word_t                 w_tw;
  word_t                 w_sum;

  assign w_phase  = r_cnt[INDEX];
  assign tw_phase = w_phase;

  sdf_delay_buffer #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (w_buf_wr),
    .dout  (w_buf_rd)
  );

  // Phase 0 parks the new sample and retires the stored difference through
  // the twiddle multiply; phase 1 emits the sum and stores the difference.
  always_comb begin
    w_a   = word_t'(w_buf_rd);
    w_b   = word_t'(stage_in);
    w_tw  = word_t'(tw_factor);
    w_sum = mod_add(w_a, w_b, c_q);
`ifdef INTT_STAGE_SCALE_EN
    w_sum = mod_half(w_sum, c_q);
`endif
    if (w_phase) begin
      w_result = DATA_WIDTH'(w_sum);
      w_buf_wr = DATA_WIDTH'(mod_sub(w_a, w_b, c_q));
    end else begin
      w_result = DATA_WIDTH'(mod_mul(w_a, w_tw, c_q));
      w_buf_wr = stage_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_primed  <= 1'b0;
      stage_out <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      r_cnt     <= r_cnt + (INDEX + 1)'(1);
      stage_out <= w_result;
      // The first phase-0 block multiplies reset contents and is dropped.
      out_valid <= r_primed | w_phase;
      if (w_phase) r_primed <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule : intt_sdf_stage
`default_nettype wire

// File: tb/tb_intt_sdf_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_intt_sdf_stage: scoreboard bench over stages with D = 1,4,8,32  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_intt_sdf_stage;

  localparam int              NS = 4;
  localparam longint unsigned Q  = 7681;

  typedef struct {
    int              slot;
    longint unsigned val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [NS];
  logic [63:0] stage_in  [NS];
  logic [63:0] tw_factor [NS];
  logic        tw_phase  [NS];
  logic [63:0] stage_out [NS];
  logic        out_valid [NS];
  logic        iv_seen   [NS];

  exp_t            exp_q[$];
  longint unsigned hx[$];
  exp_t            mon_e;
  int              total = 0;
  int              bad   = 0;

  always #5 clk = ~clk;

  function automatic int slot_idx(input int s);
    case (s)
      0:       return 0;
      1:       return 2;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  generate
    for (genvar g = 0; g < NS; g++) begin : g_dut
      intt_sdf_stage #(
        .DATA_WIDTH (64),
        .MODULO     (7681),
        .INDEX      ((g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 5)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[g]),
        .stage_in  (stage_in[g]),
        .tw_factor (tw_factor[g]),
        .tw_phase  (tw_phase[g]),
        .stage_out (stage_out[g]),
        .out_valid (out_valid[g])
      );
    end
  endgenerate

  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) iv_seen[k] <= in_valid[k];
  end

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int k = 0; k < NS; k++) begin
        if (rst_n && out_valid[k]) begin
          total++;
          if (!iv_seen[k]) begin
            bad++;
            $display("FAIL valid_after_gap slot=%0d got out_valid=1 required 0", k);
          end
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_output slot=%0d got %0d required no output", k, stage_out[k]);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.slot != k || stage_out[k] !== mon_e.val) begin
              bad++;
              $display("FAIL stage_out slot=%0d got %0d required %0d (slot %0d)",
                       k, stage_out[k], mon_e.val, mon_e.slot);
            end
          end
        end
      end
    end
  endtask

  // Reference: accepted sample t sits in block t/D; odd blocks emit sums of
  // (t-D, t); even blocks from the third on emit (x[t-2D]-x[t-D])*tw[t].
  task automatic send(input int s, input logic v, input longint unsigned x,
                      input longint unsigned tw);
    int              d, n, blk;
    longint unsigned r;
    d = 1 << slot_idx(s);
    n = hx.size();
    blk = n / d;
    in_valid[s]  = v;
    stage_in[s]  = x;
    tw_factor[s] = tw;
    if (v) begin
      total++;
      if (tw_phase[s] !== ((blk % 2) == 1)) begin
        bad++;
        $display("FAIL tw_phase slot=%0d sample=%0d got %0b required %0b",
                 s, n, tw_phase[s], (blk % 2) == 1);
      end
      if ((blk % 2) == 1) begin
        r = (hx[n-d] + x) % Q;
`ifdef INTT_STAGE_SCALE_EN
        r = (r % 2 == 0) ? r / 2 : (r + Q) / 2;
`endif
        exp_q.push_back('{slot: s, val: r});
      end else if (blk >= 2) begin
        r = ((hx[n-2*d] + Q - hx[n-d]) % Q) * tw % Q;
        exp_q.push_back('{slot: s, val: r});
      end
      hx.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid[s] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    for (int k = 0; k < NS; k++) begin
      total++;
      if (stage_out[k] !== 64'd0 || out_valid[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state slot=%0d got out=%0d valid=%0b required 0/0",
                 k, stage_out[k], out_valid[k]);
      end
    end
    hx.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_outputs got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic rand_run(input int s, input int cnt, input int gap_pct);
    for (int i = 0; i < cnt; i++) begin
      if ($urandom_range(99) < gap_pct) send(s, 1'b0, 0, 0);
      send(s, 1'b1, $urandom_range(7680), $urandom_range(7680));
    end
    for (int i = 0; i < (1 << slot_idx(s)); i++) send(s, 1'b1, $urandom_range(7680), 1);
    settle();
  endtask

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < NS; k++) begin
      in_valid[k]  = 1'b0;
      stage_in[k]  = '0;
      tw_factor[k] = '0;
    end
    fork
      monitor();
    join_none

    // D=1 directed cases
    do_reset();
    send(0, 1'b1, 5, 2); send(0, 1'b1, 3, 2); send(0, 1'b1, 0, 2);
    settle();
    do_reset();
    send(0, 1'b1, 3, 1); send(0, 1'b1, 5, 1); send(0, 1'b1, 9, 1);
    settle();
    do_reset();
    send(0, 1'b1, 7680, 1); send(0, 1'b1, 1, 1);
    send(0, 1'b1, 4, 1);    send(0, 1'b1, 3, 1); send(0, 1'b1, 0, 1);
    settle();
    do_reset();
    rand_run(0, 40, 30);

    // D=32 ramp with drain, then random frames with gaps
    do_reset();
    for (int i = 0; i < 64; i++) send(3, 1'b1, i, 1);
    for (int i = 0; i < 32; i++) send(3, 1'b1, $urandom_range(7680), 1);
    settle();
    do_reset();
    rand_run(3, 128, 25);

    // D=4 with in_valid toggling every cycle
    do_reset();
    for (int i = 0; i < 36; i++) begin
      send(1, 1'b1, $urandom_range(7680), $urandom_range(7680));
      send(1, 1'b0, $urandom_range(7680), $urandom_range(7680));
    end
    settle();

    // D=8: reset mid-block, then a fresh frame
    do_reset();
    for (int i = 0; i < 12; i++) send(2, 1'b1, $urandom_range(7680), $urandom_range(7680));
    do_reset();
    rand_run(2, 32, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_intt_sdf_stage
`default_nettype wire
